// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text display controller.
//   COLOR_W    : width of one pixel colour
//   N_FIELDS   : number of text generators feeding the controller
//   BG_COLOR   : colour shown in the visible area when no field is granted
//   GRANT_NONE : grant code meaning "no field owns this pixel"
//   state_e    : controller state (blank until the first frame boundary, then run)
package vga_text_pkg;

  localparam int                 COLOR_W    = 3;
  localparam int                 N_FIELDS   = 3;
  localparam logic [COLOR_W-1:0] BG_COLOR   = 3'b000;
  localparam logic [1:0]         GRANT_NONE = 2'd3;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_e;

endpackage

// File: rtl/vga_text_ctrl_debouncer.sv
// One-bit switch debouncer: 2-FF synchroniser followed by a stability counter.
// The debounced output only follows the synchronised input after it has held a
// new value for DEBOUNCE_CNT consecutive cycles; any bounce restarts the count.
// Ports:
//   clk      : pixel clock
//   reset    : asynchronous active-low reset
//   sw_in    : raw, asynchronous switch level
//   stable_o : debounced switch level
module switch_debouncer #(
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic stable_o
);

  localparam int                CNT_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-state of the stability counter and the debounced level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = {CNT_W{1'b0}};
    if (sync_q != stable_q) begin
      // The count reaching CNT_MAX marks DEBOUNCE_CNT cycles of disagreement.
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser, counter and debounced level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      meta_q   <= sw_in;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/vga_text_ctrl.sv
// Controller/arbiter between the switches and the three text generators.
// Debounced switches are latched into per-field enables only at frame
// boundaries so a field never appears or vanishes mid-frame. Overlapping glyph
// pixels are resolved with field 0 highest priority; field 2 additionally
// blinks with a half-period of BLINK_FRAMES frames.
// Ports:
//   clk        : pixel clock
//   reset      : asynchronous active-low reset
//   swt        : raw switches, bit i enables field i
//   vsync      : VGA vsync, active-low pulse
//   video_on   : visible-area flag, aligned with text_on/field_rgb
//   text_on    : field i has a glyph pixel at the current pixel
//   field_rgb  : {f2,f1,f0} colours
//   rgb_text   : arbitrated pixel colour (registered)
//   field_en   : enables latched at the last frame boundary
//   grant      : granted field 0..2, or 3 for none (registered with rgb_text)
//   frame_tick : one-cycle pulse per vsync falling edge
//   blink      : blink phase; field 2 is shown only while high
module vga_text_ctrl
  import vga_text_pkg::*;
#(
  parameter int                 DEBOUNCE_CNT = 20,
  parameter int                 BLINK_FRAMES = 30,
  parameter int                 COLOR_W      = vga_text_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR     = vga_text_pkg::BG_COLOR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             swt,
  input  logic                   vsync,
  input  logic                   video_on,
  input  logic [2:0]             text_on,
  input  logic [3*COLOR_W-1:0]   field_rgb,
  output logic [COLOR_W-1:0]     rgb_text,
  output logic [2:0]             field_en,
  output logic [1:0]             grant,
  output logic                   frame_tick,
  output logic                   blink
);

  localparam int               FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0]  FC_MAX = FC_W'(BLINK_FRAMES - 1);

  logic [N_FIELDS-1:0] stable_s;
  logic [N_FIELDS-1:0] act_s;

  state_e              state_q,      state_d;
  logic                vsync_d_q,    vsync_d_d;
  logic                frame_tick_q, frame_tick_d;
  logic [FC_W-1:0]     frame_cnt_q,  frame_cnt_d;
  logic                blink_q,      blink_d;
  logic [2:0]          field_en_q,   field_en_d;
  logic [COLOR_W-1:0]  rgb_q,        rgb_d;
  logic [1:0]          grant_q,      grant_d;

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .sw_in    (swt[i]),
      .stable_o (stable_s[i])
    );
  end

  // Field 2 is masked during the dark blink phase; fields 0 and 1 never blink.
  assign act_s = text_on & field_en_q & {blink_q, 1'b1, 1'b1};

  // Frame boundary detection, enable latching, blink counter and state.
  always_comb begin
    vsync_d_d    = vsync;
    frame_tick_d = vsync_d_q & ~vsync;
    field_en_d   = field_en_q;
    frame_cnt_d  = frame_cnt_q;
    blink_d      = blink_q;
    state_d      = state_q;
    if (frame_tick_q) begin
      // stable_s is sampled before this edge updates it, so a debounce
      // completing on this very edge waits for the next boundary.
      field_en_d = stable_s;
      if (frame_cnt_q == FC_MAX) begin
        frame_cnt_d = {FC_W{1'b0}};
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
      case (state_q)
        WAIT_FRAME: state_d = RUN;
        RUN:        state_d = RUN;
        default:    state_d = WAIT_FRAME;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Fixed-priority arbitration; output is blank until the first frame boundary.
  always_comb begin
    rgb_d   = {COLOR_W{1'b0}};
    grant_d = GRANT_NONE;
    case (state_q)
      WAIT_FRAME: begin
        rgb_d   = {COLOR_W{1'b0}};
        grant_d = GRANT_NONE;
      end
      RUN: begin
        if (!video_on) begin
          rgb_d   = {COLOR_W{1'b0}};
          grant_d = GRANT_NONE;
        end else if (act_s[0]) begin
          rgb_d   = field_rgb[COLOR_W-1:0];
          grant_d = 2'd0;
        end else if (act_s[1]) begin
          rgb_d   = field_rgb[2*COLOR_W-1:COLOR_W];
          grant_d = 2'd1;
        end else if (act_s[2]) begin
          rgb_d   = field_rgb[3*COLOR_W-1:2*COLOR_W];
          grant_d = 2'd2;
        end else begin
          rgb_d   = BG_COLOR;
          grant_d = GRANT_NONE;
        end
      end
      default: begin
        rgb_d   = {COLOR_W{1'b0}};
        grant_d = GRANT_NONE;
      end
    endcase
  end

  // All controller state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_FRAME;
      vsync_d_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= {FC_W{1'b0}};
      blink_q      <= 1'b0;
      field_en_q   <= 3'b000;
      rgb_q        <= {COLOR_W{1'b0}};
      grant_q      <= GRANT_NONE;
    end else begin
      state_q      <= state_d;
      vsync_d_q    <= vsync_d_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      field_en_q   <= field_en_d;
      rgb_q        <= rgb_d;
      grant_q      <= grant_d;
    end
  end

  assign rgb_text   = rgb_q;
  assign field_en   = field_en_q;
  assign grant      = grant_q;
  assign frame_tick = frame_tick_q;
  assign blink      = blink_q;

endmodule
